router_pkt_fifo: RTL and testbench

- Parametrised, packet-aware successor of the per-port router FIFO; one instance per output port of the 1x3 router.
- Sits between the router register/FSM write side and the destination read side.
- Stores a first-byte (lfd) tag per word and decodes it on read into sop/eop markers from the header length field.
- Adds packet accounting, fill level, almost-full/empty thresholds and sticky overflow/underflow error flags.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fifo_mem.sv | 38 +++
 rtl/router_pkt_fifo.sv | 159 +++++++++++++++
 tb/tb_router_pkt_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router output-port packet FIFO.
// The header length field sits in the upper bits of the first byte of a packet.
package router_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned LEN_LSB    = 2;
  localparam int unsigned LEN_MAX_W  = 30;
  localparam int unsigned LEN_RES_W  = LEN_MAX_W + 1;

  // Occupancy counters must be able to represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [LEN_RES_W-1:0] pkt_len(input logic [LEN_MAX_W-1:0] len_field);
    return {1'b0, len_field} + LEN_RES_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// FIFO storage array: one synchronous write port and one registered read port.
// Only the read register is resettable; the array itself holds no reset.
module router_fifo_mem #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to raddr returns the old contents (read-before-write).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-port FIFO of the 1x3 router: stores a header tag per word,
// frames popped words with sop/eop, and tracks occupancy, packets and errors.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned DEPTH     = DEPTH_DEF,
  parameter  int unsigned AF_MARGIN = 2,
  parameter  int unsigned AE_MARGIN = 2,
  localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              sop,
  output logic              eop,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned REM_W  = DATA_W - 1;
  localparam int unsigned WORD_W = DATA_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [REM_W-1:0]  rem;
  logic [REM_W-1:0]  rem_eff;
  logic [DEPTH-1:0]  tag_q;
  logic [WORD_W-1:0] rd_word;
  logic              rd_acc;
  logic              wr_acc;
  logic              mem_we;
  logic              mem_re;
  logic              head_tag;
  logic              pkt_inc;
  logic              pkt_dec;

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(DEPTH - AF_MARGIN));
  assign almost_empty = (count <= CNT_W'(AE_MARGIN));

  assign rd_acc = read_enb && !empty;
  assign wr_acc = write_enb && (!full || rd_acc);
  assign mem_we = wr_acc && !soft_reset;
  assign mem_re = rd_acc && !soft_reset;

  assign head_tag = tag_q[rd_ptr];
  assign pkt_inc  = wr_acc && lfd_state;
  assign pkt_dec  = rd_acc && head_tag;

  router_fifo_mem #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (soft_reset),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata ({lfd_state, data_in}),
    .re    (mem_re),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign data_out = rd_word[DATA_W-1:0];
  assign sop      = rd_word[DATA_W];

  // Tag bits mirrored in flops so the pop cycle knows whether the head word is a header.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      tag_q[wr_ptr] <= lfd_state;
    end
  end

  // Remaining-byte count after folding in the word currently on data_out.
  always_comb begin
    rem_eff = rem;
    if (out_valid) begin
      if (sop) begin
        rem_eff = REM_W'(pkt_len(LEN_MAX_W'(data_out[DATA_W-1:LEN_LSB])));
      end else if (rem != '0) begin
        rem_eff = rem - REM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_cnt   <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      eop       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_cnt   <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      eop       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (wr_acc && !rd_acc) begin
        count <= count + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_W'(1);
      end

      if (pkt_inc && !pkt_dec) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end else if (pkt_dec && !pkt_inc) begin
        pkt_cnt <= pkt_cnt - CNT_W'(1);
      end

      rem       <= rem_eff;
      out_valid <= rd_acc;
      // A header pop never carries eop, which also covers truncated packets.
      if (rd_acc) begin
        eop <= !head_tag && (rem_eff == REM_W'(1));
      end

      if (write_enb && full && !rd_acc) begin
        overflow <= 1'b1;
      end
      if (read_enb && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: reset, framing, full/wrap, underflow,
// soft reset and truncated-packet recovery, with hand-computed expectations.
module tb_router_pkt_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rstn;
  logic              soft_reset;
  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              sop;
  logic              eop;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              overflow;
  logic              underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] frm_w [5] = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5A};
  logic [7:0] sr_w  [9] = '{8'h0C, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h08, 8'hC1, 8'hC2, 8'hC3};
  logic       sr_t  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] tr_w  [5] = '{8'h14, 8'h31, 8'h32, 8'h00, 8'h99};
  logic       tr_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       tr_e  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  router_pkt_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (2),
    .AE_MARGIN (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .read_enb     (read_enb),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .sop          (sop),
    .eop          (eop),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .pkt_cnt      (pkt_cnt),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic we, input logic lfd, input logic [7:0] d, input logic re);
    write_enb = we;
    lfd_state = lfd;
    data_in   = d;
    read_enb  = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn       = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = '0;
    read_enb   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of a write
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("pre_rst_dout", 32'(data_out), 32'hAA);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    write_enb = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("rst_dout", 32'(data_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("post_rst_count", 32'(count), 32'd0);

    // Packet framing: header length 3, three payload bytes, parity
    for (int i = 0; i < 5; i++) cyc(1'b1, (i == 0), frm_w[i], 1'b0);
    check("frm_count", 32'(count), 32'd5);
    check("frm_pkt_cnt", 32'(pkt_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("frm_dout%0d", i), 32'(data_out), 32'(frm_w[i]));
      check($sformatf("frm_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("frm_sop%0d", i), 32'(sop), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("frm_eop%0d", i), 32'(eop), (i == 4) ? 32'd1 : 32'd0);
      if (i == 0) check("frm_pkt_cnt_rd", 32'(pkt_cnt), 32'd0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("frm_idle_valid", 32'(out_valid), 32'd0);
    check("frm_idle_hold", 32'(data_out), 32'h5A);

    // Fill to full, overflow, full-rate read/write across pointer wrap, drain
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(16 + i), 1'b0);
      if (i == 12) check("af_at13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_at14", 32'(almost_full), 32'd1);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd16);
    cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    for (int j = 0; j < 4; j++) begin
      cyc(1'b1, 1'b0, 8'(64 + j), 1'b1);
      check($sformatf("rw_dout%0d", j), 32'(data_out), 32'(16 + j));
      check($sformatf("rw_count%0d", j), 32'(count), 32'd16);
    end
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("drain%0d", k), 32'(data_out), (k < 12) ? 32'(20 + k) : 32'(64 + k - 12));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Underflow, and write+read on empty
    check("udf_before", 32'(underflow), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, 8'h77, 1'b1);
    check("wr_rd_empty_count", 32'(count), 32'd1);
    check("wr_rd_empty_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("wr_rd_empty_dout", 32'(data_out), 32'h77);
    check("wr_rd_empty_count2", 32'(count), 32'd0);

    // Soft reset flushes two stored packets and sticky flags, dropping a concurrent write
    for (int i = 0; i < 9; i++) cyc(1'b1, sr_t[i], sr_w[i], 1'b0);
    check("sr_count", 32'(count), 32'd9);
    check("sr_pkt_cnt", 32'(pkt_cnt), 32'd2);
    check("sr_ovf_before", 32'(overflow), 32'd1);
    soft_reset = 1'b1;
    cyc(1'b1, 1'b0, 8'hDD, 1'b0);
    soft_reset = 1'b0;
    check("sr_count_clr", 32'(count), 32'd0);
    check("sr_pkt_clr", 32'(pkt_cnt), 32'd0);
    check("sr_ovf_clr", 32'(overflow), 32'd0);
    check("sr_udf_clr", 32'(underflow), 32'd0);
    check("sr_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("sr_write_dropped", 32'(count), 32'd0);

    // Truncated packet: header length 5, two bytes, then a length-0 header and its parity
    for (int i = 0; i < 5; i++) cyc(1'b1, tr_t[i], tr_w[i], 1'b0);
    check("tr_pkt_cnt", 32'(pkt_cnt), 32'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("tr_dout%0d", i), 32'(data_out), 32'(tr_w[i]));
      check($sformatf("tr_sop%0d", i), 32'(sop), 32'(tr_t[i]));
      check($sformatf("tr_eop%0d", i), 32'(eop), 32'(tr_e[i]));
    end
    check("tr_pkt_cnt_end", 32'(pkt_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
